// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage MIPS core. It decodes the
// instruction in D, tracks the type, destination and result-ready countdown
// (tnew) of the instructions in E, M and W, and from that state drives the
// stall request and every forwarding-mux select of the datapath.
//
// Ports
//   clk       in  1 : core clock, all state updates on the rising edge
//   reset     in  1 : synchronous active-high, clears all tracking state
//   d_type    in  4 : classifier code of the D instruction (9..15 = nop)
//   d_rs      in  5 : IR_D[25:21]
//   d_rt      in  5 : IR_D[20:16]
//   d_rd      in  5 : IR_D[15:11]
//   stall     out 1 : freeze PC and IF/ID, bubble into ID/EX
//   fwd_d_rs  out 2 : D compare rs    0 = GRF, 1 = M result, 2 = E result
//   fwd_d_rt  out 2 : D compare rt    same encoding
//   fwd_e_rs  out 2 : ALU operand A   0 = ID/EX, 1 = W data, 2 = M result
//   fwd_e_rt  out 2 : ALU operand B   same encoding
//   fwd_m_rt  out 1 : DM write data   0 = EX/MEM, 1 = W data
//   e_type    out 4 : tracked type in E
//   m_type    out 4 : tracked type in M
//   w_type    out 4 : tracked type in W
// ---------------------------------------------------------------------------
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_type,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_rd,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt,
  output logic [3:0] e_type,
  output logic [3:0] m_type,
  output logic [3:0] w_type
);

  localparam logic [3:0] TYPE_NOP   = 4'd0;
  localparam logic [3:0] TYPE_CAL_R = 4'd1;
  localparam logic [3:0] TYPE_CAL_I = 4'd2;
  localparam logic [3:0] TYPE_BEQ   = 4'd3;
  localparam logic [3:0] TYPE_LOAD  = 4'd4;
  localparam logic [3:0] TYPE_SAVE  = 4'd5;
  localparam logic [3:0] TYPE_J     = 4'd6;
  localparam logic [3:0] TYPE_JAL   = 4'd7;
  localparam logic [3:0] TYPE_JR    = 4'd8;

  // Tracking state for the instructions in E, M and W.
  logic [3:0] r_eType;
  logic [4:0] r_eRs;
  logic [4:0] r_eRt;
  logic [4:0] r_eDest;
  logic [1:0] r_eTnew;
  logic [3:0] r_mType;
  logic [4:0] r_mRt;
  logic [4:0] r_mDest;
  logic [1:0] r_mTnew;
  logic [3:0] r_wType;
  logic [4:0] r_wDest;

  // Decoded view of the D instruction.
  logic [4:0] w_dDest;
  logic [1:0] w_dTnew;
  logic       w_useRs;
  logic [1:0] w_tuseRs;
  logic       w_useRt;
  logic [1:0] w_tuseRt;
  logic       w_stallRs;
  logic       w_stallRt;
  logic       w_stall;
  logic [1:0] w_fwdDRs;
  logic [1:0] w_fwdDRt;
  logic [1:0] w_fwdERs;
  logic [1:0] w_fwdERt;
  logic       w_fwdMRt;
  logic [1:0] w_mTnewNext;

  // Decode D: destination, result latency at E entry and operand use times.
  // Codes that are not listed (nop, J, 9..15) neither write nor read.
  always_comb begin
    w_dDest  = 5'd0;
    w_dTnew  = 2'd0;
    w_useRs  = 1'b0;
    w_tuseRs = 2'd0;
    w_useRt  = 1'b0;
    w_tuseRt = 2'd0;
    case (d_type)
      TYPE_CAL_R: begin
        w_dDest  = d_rd;
        w_dTnew  = 2'd1;
        w_useRs  = 1'b1;
        w_tuseRs = 2'd1;
        w_useRt  = 1'b1;
        w_tuseRt = 2'd1;
      end
      TYPE_CAL_I: begin
        w_dDest  = d_rt;
        w_dTnew  = 2'd1;
        w_useRs  = 1'b1;
        w_tuseRs = 2'd1;
      end
      TYPE_BEQ: begin
        w_useRs  = 1'b1;
        w_tuseRs = 2'd0;
        w_useRt  = 1'b1;
        w_tuseRt = 2'd0;
      end
      TYPE_LOAD: begin
        w_dDest  = d_rt;
        w_dTnew  = 2'd2;
        w_useRs  = 1'b1;
        w_tuseRs = 2'd1;
      end
      TYPE_SAVE: begin
        w_useRs  = 1'b1;
        w_tuseRs = 2'd1;
        w_useRt  = 1'b1;
        w_tuseRt = 2'd2;
      end
      TYPE_JAL: begin
        w_dDest  = 5'd31;
        w_dTnew  = 2'd0;
      end
      TYPE_JR: begin
        w_useRs  = 1'b1;
        w_tuseRs = 2'd0;
      end
      default: begin
        w_dDest  = 5'd0;
      end
    endcase
  end

  // A used source stalls when a producer in E or M will not have its result
  // ready by the time the consumer needs it. Register $0 never matches.
  always_comb begin
    w_stallRs = w_useRs && (d_rs != 5'd0) &&
                (((r_eDest == d_rs) && (r_eTnew > w_tuseRs)) ||
                 ((r_mDest == d_rs) && (r_mTnew > w_tuseRs)));
    w_stallRt = w_useRt && (d_rt != 5'd0) &&
                (((r_eDest == d_rt) && (r_eTnew > w_tuseRt)) ||
                 ((r_mDest == d_rt) && (r_mTnew > w_tuseRt)));
    w_stall   = w_stallRs || w_stallRt;
  end

  // Forwarding selects, nearest ready producer first. W never forwards to D
  // because the register file writes through in the same cycle. W results
  // are always ready, so no tnew is tracked there.
  always_comb begin
    w_fwdDRs = 2'd0;
    if ((r_eDest != 5'd0) && (r_eDest == d_rs) && (r_eTnew == 2'd0))
      w_fwdDRs = 2'd2;
    else if ((r_mDest != 5'd0) && (r_mDest == d_rs) && (r_mTnew == 2'd0))
      w_fwdDRs = 2'd1;

    w_fwdDRt = 2'd0;
    if ((r_eDest != 5'd0) && (r_eDest == d_rt) && (r_eTnew == 2'd0))
      w_fwdDRt = 2'd2;
    else if ((r_mDest != 5'd0) && (r_mDest == d_rt) && (r_mTnew == 2'd0))
      w_fwdDRt = 2'd1;

    w_fwdERs = 2'd0;
    if ((r_mDest != 5'd0) && (r_mDest == r_eRs) && (r_mTnew == 2'd0))
      w_fwdERs = 2'd2;
    else if ((r_wDest != 5'd0) && (r_wDest == r_eRs))
      w_fwdERs = 2'd1;

    w_fwdERt = 2'd0;
    if ((r_mDest != 5'd0) && (r_mDest == r_eRt) && (r_mTnew == 2'd0))
      w_fwdERt = 2'd2;
    else if ((r_wDest != 5'd0) && (r_wDest == r_eRt))
      w_fwdERt = 2'd1;

    w_fwdMRt = (r_wDest != 5'd0) && (r_wDest == r_mRt);
  end

  // Outputs are held at zero while reset is asserted so they are defined
  // even before the first clearing edge.
  always_comb begin
    stall    = !reset && w_stall;
    fwd_d_rs = reset ? 2'd0 : w_fwdDRs;
    fwd_d_rt = reset ? 2'd0 : w_fwdDRt;
    fwd_e_rs = reset ? 2'd0 : w_fwdERs;
    fwd_e_rt = reset ? 2'd0 : w_fwdERt;
    fwd_m_rt = !reset && w_fwdMRt;
    e_type   = reset ? 4'd0 : r_eType;
    m_type   = reset ? 4'd0 : r_mType;
    w_type   = reset ? 4'd0 : r_wType;
  end

  // Countdown saturates at zero once the result exists.
  assign w_mTnewNext = (r_eTnew == 2'd0) ? 2'd0 : (r_eTnew - 2'd1);

  // Advance the tracking pipeline; a stall turns the E entry into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_eType <= TYPE_NOP;
      r_eRs   <= 5'd0;
      r_eRt   <= 5'd0;
      r_eDest <= 5'd0;
      r_eTnew <= 2'd0;
      r_mType <= TYPE_NOP;
      r_mRt   <= 5'd0;
      r_mDest <= 5'd0;
      r_mTnew <= 2'd0;
      r_wType <= TYPE_NOP;
      r_wDest <= 5'd0;
    end else begin
      r_wType <= r_mType;
      r_wDest <= r_mDest;
      r_mType <= r_eType;
      r_mRt   <= r_eRt;
      r_mDest <= r_eDest;
      r_mTnew <= w_mTnewNext;
      if (w_stall) begin
        r_eType <= TYPE_NOP;
        r_eRs   <= 5'd0;
        r_eRt   <= 5'd0;
        r_eDest <= 5'd0;
        r_eTnew <= 2'd0;
      end else begin
        r_eType <= d_type;
        r_eRs   <= d_rs;
        r_eRt   <= d_rt;
        r_eDest <= w_dDest;
        r_eTnew <= w_dTnew;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Each step drives one D instruction just
// after a rising edge and checks the combinational outputs mid-cycle
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] CAL_R = 4'd1;
  localparam logic [3:0] CAL_I = 4'd2;
  localparam logic [3:0] BEQ   = 4'd3;
  localparam logic [3:0] LOAD  = 4'd4;
  localparam logic [3:0] SAVE  = 4'd5;
  localparam logic [3:0] JAL   = 4'd7;
  localparam logic [3:0] JR    = 4'd8;

  logic       clk;
  logic       reset;
  logic [3:0] dType;
  logic [4:0] dRs;
  logic [4:0] dRt;
  logic [4:0] dRd;
  logic       stall;
  logic [1:0] fwdDRs;
  logic [1:0] fwdDRt;
  logic [1:0] fwdERs;
  logic [1:0] fwdERt;
  logic       fwdMRt;
  logic [3:0] eType;
  logic [3:0] mType;
  logic [3:0] wType;

  int testCount = 0;
  int failCount = 0;

  hazard_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .d_type   (dType),
    .d_rs     (dRs),
    .d_rt     (dRt),
    .d_rd     (dRd),
    .stall    (stall),
    .fwd_d_rs (fwdDRs),
    .fwd_d_rt (fwdDRt),
    .fwd_e_rs (fwdERs),
    .fwd_e_rt (fwdERt),
    .fwd_m_rt (fwdMRt),
    .e_type   (eType),
    .m_type   (mType),
    .w_type   (wType)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle: drive reset and the D fields just after the edge,
  // then move to mid-cycle where the outputs are checked.
  task automatic applyStimulus(input logic rst, input logic [3:0] t,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd);
    @(posedge clk);
    #1;
    reset = rst;
    dType = t;
    dRs   = rs;
    dRt   = rt;
    dRd   = rd;
    #3;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, NOP, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    // Reset with a load sitting in D: nothing may leak through.
    reset = 1'b1;
    dType = LOAD;
    dRs   = 5'd0;
    dRt   = 5'd1;
    dRd   = 5'd0;
    #2;
    checkOutput("rst_pre_stall", {3'd0, stall}, 4'd0);
    checkOutput("rst_pre_fwd_d_rs", {2'd0, fwdDRs}, 4'd0);
    checkOutput("rst_pre_e_type", eType, 4'd0);
    applyStimulus(1'b1, LOAD, 5'd0, 5'd1, 5'd0);
    checkOutput("rst_e_type", eType, 4'd0);
    checkOutput("rst_m_type", mType, 4'd0);
    checkOutput("rst_w_type", wType, 4'd0);
    checkOutput("rst_stall", {3'd0, stall}, 4'd0);
    checkOutput("rst_fwd_e_rs", {2'd0, fwdERs}, 4'd0);
    checkOutput("rst_fwd_m_rt", {3'd0, fwdMRt}, 4'd0);
    flush();

    // lw $1 ; addu $2,$1,$3 -> one stall, then W forwards to E
    applyStimulus(1'b0, LOAD, 5'd0, 5'd1, 5'd0);
    checkOutput("lw_cal_nostall_first", {3'd0, stall}, 4'd0);
    applyStimulus(1'b0, CAL_R, 5'd1, 5'd3, 5'd2);
    checkOutput("lw_cal_stall1", {3'd0, stall}, 4'd1);
    checkOutput("lw_cal_e_type", eType, LOAD);
    applyStimulus(1'b0, CAL_R, 5'd1, 5'd3, 5'd2);
    checkOutput("lw_cal_stall_release", {3'd0, stall}, 4'd0);
    checkOutput("lw_cal_bubble_e", eType, 4'd0);
    checkOutput("lw_cal_m_type", mType, LOAD);
    applyStimulus(1'b0, NOP, 5'd0, 5'd0, 5'd0);
    checkOutput("lw_cal_fwd_e_rs", {2'd0, fwdERs}, 4'd1);
    checkOutput("lw_cal_fwd_e_rt", {2'd0, fwdERt}, 4'd0);
    checkOutput("lw_cal_e_type_cal", eType, CAL_R);
    checkOutput("lw_cal_w_type", wType, LOAD);
    flush();

    // lw $1 ; beq $1,$0 -> two stalls, then GRF write-through
    applyStimulus(1'b0, LOAD, 5'd0, 5'd1, 5'd0);
    applyStimulus(1'b0, BEQ, 5'd1, 5'd0, 5'd0);
    checkOutput("lw_beq_stall1", {3'd0, stall}, 4'd1);
    applyStimulus(1'b0, BEQ, 5'd1, 5'd0, 5'd0);
    checkOutput("lw_beq_stall2", {3'd0, stall}, 4'd1);
    applyStimulus(1'b0, BEQ, 5'd1, 5'd0, 5'd0);
    checkOutput("lw_beq_release", {3'd0, stall}, 4'd0);
    checkOutput("lw_beq_fwd_d_rs", {2'd0, fwdDRs}, 4'd0);
    flush();

    // addu $4,$5,$6 ; beq $4,$4 -> one stall, then both from M
    applyStimulus(1'b0, CAL_R, 5'd5, 5'd6, 5'd4);
    applyStimulus(1'b0, BEQ, 5'd4, 5'd4, 5'd0);
    checkOutput("cal_beq_stall", {3'd0, stall}, 4'd1);
    checkOutput("cal_beq_fwd_wait", {2'd0, fwdDRs}, 4'd0);
    applyStimulus(1'b0, BEQ, 5'd4, 5'd4, 5'd0);
    checkOutput("cal_beq_release", {3'd0, stall}, 4'd0);
    checkOutput("cal_beq_fwd_d_rs", {2'd0, fwdDRs}, 4'd1);
    checkOutput("cal_beq_fwd_d_rt", {2'd0, fwdDRt}, 4'd1);
    flush();

    // jal ; jr $31 -> no stall, PC+8 from E
    applyStimulus(1'b0, JAL, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, JR, 5'd31, 5'd0, 5'd0);
    checkOutput("jal_jr_stall", {3'd0, stall}, 4'd0);
    checkOutput("jal_jr_fwd_d_rs", {2'd0, fwdDRs}, 4'd2);
    checkOutput("jal_jr_e_type", eType, JAL);
    flush();

    // lw $1 ; sw $1,0($2) -> no stall, W forwards store data into M
    applyStimulus(1'b0, LOAD, 5'd0, 5'd1, 5'd0);
    applyStimulus(1'b0, SAVE, 5'd2, 5'd1, 5'd0);
    checkOutput("lw_sw_stall", {3'd0, stall}, 4'd0);
    checkOutput("lw_sw_fwd_d_rt", {2'd0, fwdDRt}, 4'd0);
    applyStimulus(1'b0, NOP, 5'd0, 5'd0, 5'd0);
    checkOutput("lw_sw_fwd_e_rt", {2'd0, fwdERt}, 4'd0);
    checkOutput("lw_sw_e_type", eType, SAVE);
    applyStimulus(1'b0, NOP, 5'd0, 5'd0, 5'd0);
    checkOutput("lw_sw_fwd_m_rt", {3'd0, fwdMRt}, 4'd1);
    checkOutput("lw_sw_m_type", mType, SAVE);
    flush();

    // ori $0,$0,5 ; addu $2,$0,$0 -> $0 never stalls or forwards
    applyStimulus(1'b0, CAL_I, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, CAL_R, 5'd0, 5'd0, 5'd2);
    checkOutput("r0_stall", {3'd0, stall}, 4'd0);
    checkOutput("r0_fwd_d_rs", {2'd0, fwdDRs}, 4'd0);
    checkOutput("r0_fwd_d_rt", {2'd0, fwdDRt}, 4'd0);
    applyStimulus(1'b0, NOP, 5'd0, 5'd0, 5'd0);
    checkOutput("r0_fwd_e_rs", {2'd0, fwdERs}, 4'd0);
    checkOutput("r0_fwd_e_rt", {2'd0, fwdERt}, 4'd0);
    flush();

    // addu $31,$1,$1 ; jal ; jr $31 -> both E and M ready, E wins
    applyStimulus(1'b0, CAL_R, 5'd1, 5'd1, 5'd31);
    applyStimulus(1'b0, JAL, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, JR, 5'd31, 5'd0, 5'd0);
    checkOutput("prio_stall", {3'd0, stall}, 4'd0);
    checkOutput("prio_fwd_d_rs", {2'd0, fwdDRs}, 4'd2);
    flush();

    // lw $1 ; code 12 reading $1 -> treated as nop, no stall
    applyStimulus(1'b0, LOAD, 5'd0, 5'd1, 5'd0);
    applyStimulus(1'b0, 4'd12, 5'd1, 5'd1, 5'd0);
    checkOutput("code12_stall", {3'd0, stall}, 4'd0);
    flush();

    // reset during a lw -> beq stall clears everything
    applyStimulus(1'b0, LOAD, 5'd0, 5'd1, 5'd0);
    applyStimulus(1'b0, BEQ, 5'd1, 5'd0, 5'd0);
    checkOutput("midrst_stall_before", {3'd0, stall}, 4'd1);
    applyStimulus(1'b1, BEQ, 5'd1, 5'd0, 5'd0);
    applyStimulus(1'b0, BEQ, 5'd1, 5'd0, 5'd0);
    checkOutput("midrst_stall_after", {3'd0, stall}, 4'd0);
    checkOutput("midrst_e_type", eType, 4'd0);
    checkOutput("midrst_m_type", mType, 4'd0);
    checkOutput("midrst_w_type", wType, 4'd0);
    applyStimulus(1'b0, NOP, 5'd0, 5'd0, 5'd0);
    checkOutput("midrst_beq_enters_e", eType, BEQ);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sits directly downstream of the D-stage instruction classifier. It consumes the 4-bit instruction-type code and the register fields of the instruction in D, and tracks the type, destination and result-ready countdown (Tnew) of the instructions in E, M and W. From this it drives the stall signal and every forwarding-mux select in the datapath.

## Interface
- No parameters.
- `clk` in 1: core clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all tracking state.
- `d_type` in 4: classifier code for the D instruction: 1 CAL_R, 2 CAL_I, 3 BEQ, 4 LOAD, 5 SAVE, 6 J, 7 JAL, 8 JR, 0 nop. Codes 9–15 are treated as nop.
- `d_rs` in 5: IR_D[25:21].
- `d_rt` in 5: IR_D[20:16].
- `d_rd` in 5: IR_D[15:11].
- `stall` out 1: freeze PC and IF/ID, and insert a bubble into ID/EX.
- `fwd_d_rs` out 2: D compare operand rs. 0 = GRF, 1 = M result, 2 = E result (PC+8).
- `fwd_d_rt` out 2: same encoding, for rt.
- `fwd_e_rs` out 2: ALU operand A. 0 = ID/EX register, 1 = W write data, 2 = M result.
- `fwd_e_rt` out 2: ALU operand B / store data, same encoding.
- `fwd_m_rt` out 1: DM write data. 0 = EX/MEM register, 1 = W write data.
- `e_type`, `m_type`, `w_type` out 4 each: tracked type per stage, used by datapath result muxes (JAL selects PC+8).

## Operation
- **Per-D decode.**
  - dest: CAL_R→rd, CAL_I→rt, LOAD→rt, JAL→31, else 0.
  - Tnew at E entry: CAL_R/CAL_I 1, LOAD 2, JAL 0, else 0.
  - Tuse_rs: BEQ/JR 0; CAL_R/CAL_I/LOAD/SAVE 1; else none.
  - Tuse_rt: BEQ 0, CAL_R 1, SAVE 2; else none.
- **Tracking registers.**
  - E stage holds {type, rs, rt, dest, tnew}.
  - M stage holds {type, rt, dest, tnew}.
  - W stage holds {type, dest}.
- **Stall rule.** Stall is asserted (combinationally) if any used source s (rs or rt, s≠0) matches either:
  - E.dest==s with E.tnew > Tuse_s, or
  - M.dest==s with M.tnew > Tuse_s.
- **Forwarding rules.** A producer qualifies only when dest≠0, dest==source and its stage Tnew==0. When several stages qualify, the nearest stage wins.
  - D selects consider E, then M. W is not forwarded to D because the GRF writes through.
  - E selects consider M, then W.
  - `fwd_m_rt` considers W.
- **Unused sources.** A source that is unused by its instruction still forwards harmlessly. Stall considers only used sources.
- **Register $0.** dest==0 never stalls and never forwards.

## Timing
- `stall` and all `fwd_*` are combinational from the D inputs plus registered state. They are valid in the same cycle as the D inputs.
- On every rising edge, with `reset` taking priority:
  - W ← M.
  - M ← E, with tnew = max(E.tnew−1, 0).
  - E ← decoded D if `stall`==0, otherwise a bubble (all fields 0).
- Stall latency:
  - LOAD→BEQ/JR dependency: 2 stall cycles.
  - LOAD→CAL dependency: 1 cycle.
  - CAL→BEQ/JR dependency: 1 cycle.
  - LOAD→SAVE-rt dependency: 0 cycles.
- Reset values: all tracking fields 0. Hence `stall`=0, all `fwd_*`=0 and `*_type`=0 during and after reset, independent of the D inputs' effect on E.
- Reset asserted mid-stall: the next edge clears E/M/W. A stall still required by the D inputs then depends only on the new, empty state, so it deasserts.
- A simultaneous match in E and M: stall is evaluated on both; forwarding takes E (for D selects).

## Test plan
- lw $1 in D, next cycle addu $2,$1,$3 in D.
  - Required: `stall`=1 for exactly 1 cycle.
  - Then `fwd_e_rs`=1 (W) when the addu is in E.
- lw $1, then beq $1,$0.
  - Required: `stall`=1 for 2 cycles.
  - Then `fwd_d_rs`=0 (GRF write-through).
- addu $4,$5,$6, then beq $4,$4.
  - Required: 1 stall cycle.
  - Then `fwd_d_rs`=`fwd_d_rt`=1 (M).
- jal, then jr $31.
  - Required: `stall`=0.
  - `fwd_d_rs`=2 (E).
  - `e_type`=7 in that cycle.
- lw $1, then sw $1,0($2).
  - Required: no stall.
  - `fwd_m_rt`=1 when the sw is in M.
- ori $0,$0,5, then addu $2,$0,$0: no stall, all selects 0. Then assert `reset` during a lw→beq stall: next cycle `stall`=0 and `*_type`=0.
